relu_vec_pipe: RTL and testbench
================================

# relu_vec_pipe

Pipelined, backpressure-aware ReLU over a frame of M secret-shared N-bit elements, processed one element per accepted beat. The block reconstructs x = r1 + (x − r1) mod 2^N, applies ReLU with optional upper clip, and emits the result with a per-element index, last-of-frame flag and per-frame positive count. It is the sequential, vector-width successor to the single-element ReLU in the secure-inference circuit library. An optional re-masking stage outputs a fresh share instead of the plaintext.

## Interface
- N, 8, element bit-width (≥2)
- M, 4, elements per frame (≥1)
- CAP, 0, clip bound for positive results; 0 = no clip, else 1..2^(N−1)−1
- clk  input  1  clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- g_input  input  2N  garbler share {r1, r2}; r1 = [2N−1:N], r2 = [N−1:0]
- e_input  input  N  evaluator share x − r1
- i_valid  input  1  input beat valid
- i_ready  output  1  block accepts beat this cycle
- o  output  N  result (plaintext or re-masked)
- o_valid  output  1  o and side outputs valid
- o_ready  input  1  downstream accepts output
- o_idx  output  clog2(M) (min 1)  element index within frame
- o_last  output  1  o_idx == M−1
- frame_pos  output  clog2(M+1)  number of positive elements in the last completed frame

## Operation
- Encoding: x is N-bit two's complement; negative ⇔ x[N−1] = 1; x = 0 is not positive.
- Stage 1 (S1): on accept, register x = (r1 + e_input) mod 2^N (carry discarded), r2, index, last flag.
- Stage 2 (S2): y = 0 if negative; else y = min(x, CAP) if CAP ≠ 0; else y = x. Register o = y (or y − r2, see Configuration), o_idx, o_last.
- Global advance: adv = !o_valid | o_ready. i_ready = adv. When adv, S1→S2 and input→S1 simultaneously; otherwise all pipeline registers hold. Bubbles are not collapsed.
- Accept = i_valid & i_ready. Index counter increments per accept, wraps M−1 → 0; M = 1 keeps index 0, every beat last.
- Positive counter: increments when an element with x positive enters S2 (before clip). When the last element of a frame enters S2, frame_pos ← count including that element and counter ← 0.
- o_valid drops only on a cycle with o_ready = 1 and no new element entering S2.

## Timing
- Latency: accept in cycle t → o_valid in cycle t+2 with no stall.
- Throughput: one element per cycle while o_ready = 1.
- Stall: o_valid & !o_ready holds o, o_idx, o_last, o_valid and S1 constant; i_ready = 0 same cycle (combinational from o_ready).
- frame_pos updates on the same edge that the last element's o_valid rises.
- Reset (any cycle, including mid-frame): o = 0, o_valid = 0, o_idx = 0, o_last = 0, frame_pos = 0, S1 valid = 0, index and positive counters = 0. i_ready = 1 in the first cycle after reset. Partial frames are discarded; no output beat from before reset appears after it.
- i_valid while i_ready = 0: beat not accepted, no state change; source must hold.

## Configuration
- RELU_REMASK_EN defined: r2 travels with the element; o = (y − r2) mod 2^N, so the evaluator learns only a share of ReLU(x) and the garbler keeps r2.
- RELU_REMASK_EN undefined: o = y; r2 is ignored and not registered.
- frame_pos, o_idx, o_last behave identically in both builds (computed from x, not o).

## Test plan
- N=8, M=4, CAP=0, no remask, o_ready=1; beats (r1,e) = (0x10,0x05),(0xF0,0x0F),(0x80,0x00),(0x7F,0x01) → o = 0x15,0x00,0x00,0x00 (0x7F+0x01 = 0x80, negative) at t+2, o_idx 0..3, o_last on 4th, frame_pos = 1.
- CAP=6: x = 0x05 → 0x05; x = 0x40 → 0x06; x = 0xFF → 0x00.
- RELU_REMASK_EN, r2 = 0x03: x = 0x15 → o = 0x12; x = 0x90 → o = 0xFD.
- Backpressure: hold o_ready=0 for 3 cycles with o_valid=1 → o/o_idx stable, i_ready=0, no beat lost or duplicated; release → remaining beats in order.
- Reset asserted after 2 of 4 beats accepted → all outputs zero next cycle; next 4 beats form a new frame with o_idx 0..3 and correct frame_pos.
- M=1: every output beat has o_idx=0, o_last=1; frame_pos = 1 for positive x, 0 for x = 0.

Source files
------------

// File: rtl/relu_vec_pipe.sv
// relu_vec_pipe: two-stage, backpressure-aware ReLU over frames of M
// secret-shared N-bit elements, one element per accepted beat.
//   S1 reconstructs x = r1 + (x - r1) mod 2^N and tags it with the element
//   index and last-of-frame flag.
//   S2 applies ReLU with an optional upper clip (CAP) and keeps the per-frame
//   positive count.
// Optional build macro: RELU_REMASK_EN. When defined, o carries the fresh
// share (y - r2) mod 2^N instead of the plaintext ReLU result.
module relu_vec_pipe #(
  parameter int N   = 8,
  parameter int M   = 4,
  parameter int CAP = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2*N-1:0]                       g_input,
  input  logic [N-1:0]                         e_input,
  input  logic                                 i_valid,
  output logic                                 i_ready,
  output logic [N-1:0]                         o,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] o_idx,
  output logic                                 o_last,
  output logic [$clog2(M+1)-1:0]               frame_pos
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int POS_W = $clog2(M + 1);
  localparam logic signed [N-1:0] CAP_V = N'(CAP);

  logic                adv;
  logic [N-1:0]        r1;
  logic signed [N-1:0] x_in;
  logic                last_in;
  logic [IDX_W-1:0]    idx_cnt;
  logic signed [N-1:0] x_p1;
  logic [IDX_W-1:0]    idx_p1;
  logic                last_p1;
  logic                vld_p1;
  logic                pos_p1;
  logic [N-1:0]        y_p1;
  logic [N-1:0]        o_nxt;
  logic [POS_W-1:0]    pos_cnt;

  // ReLU with optional clip; zero is treated as non-positive.
  function automatic logic [N-1:0] relu_clip(input logic signed [N-1:0] x);
    logic [N-1:0] y;
    if (x <= 0)
      y = '0;
    else if ((CAP != 0) && (x > CAP_V))
      y = CAP_V;
    else
      y = x;
    return y;
  endfunction

`ifdef RELU_REMASK_EN
  logic [N-1:0] r2_p1;

  // Fresh share of the result: the evaluator sees only y - r2.
  function automatic logic [N-1:0] remask(input logic [N-1:0] y,
                                          input logic [N-1:0] r2);
    return y - r2;
  endfunction
`else
  logic unused_r2;
  assign unused_r2 = ^g_input[N-1:0];
`endif

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign adv     = !o_valid || o_ready;
  assign i_ready = adv;

  assign r1      = g_input[2*N-1:N];
  assign x_in    = r1 + e_input;
  assign last_in = (idx_cnt == IDX_W'(M - 1));

  assign pos_p1  = (x_p1 > 0);
  assign y_p1    = relu_clip(x_p1);
`ifdef RELU_REMASK_EN
  assign o_nxt   = remask(y_p1, r2_p1);
`else
  assign o_nxt   = y_p1;
`endif

  // ---- stage 0 -> 1: accept beat, reconstruct x, tag index ----

  // S1 valid flag and element index counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      idx_cnt <= '0;
    end else if (adv) begin
      vld_p1 <= i_valid;
      if (i_valid)
        idx_cnt <= last_in ? '0 : idx_cnt + 1'b1;
    end
  end

  // S1 payload; qualified by vld_p1 so it needs no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      x_p1    <= x_in;
      idx_p1  <= idx_cnt;
      last_p1 <= last_in;
`ifdef RELU_REMASK_EN
      r2_p1   <= g_input[N-1:0];
`endif
    end
  end

  // ---- stage 1 -> 2: ReLU/clip, output register, frame positive count ----

  // Output register, side outputs and per-frame positive counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      o         <= '0;
      o_valid   <= 1'b0;
      o_idx     <= '0;
      o_last    <= 1'b0;
      pos_cnt   <= '0;
      frame_pos <= '0;
    end else if (adv) begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        o      <= o_nxt;
        o_idx  <= idx_p1;
        o_last <= last_p1;
        if (last_p1) begin
          frame_pos <= pos_cnt + POS_W'(pos_p1);
          pos_cnt   <= '0;
        end else begin
          pos_cnt <= pos_cnt + POS_W'(pos_p1);
        end
      end
    end
  end

endmodule

// File: tb/tb_relu_vec_pipe.sv
// Testbench for relu_vec_pipe: three instances share one input stream
// (default N=8/M=4/CAP=0, a CAP=6 variant and an M=1 variant).
module tb_relu_vec_pipe;

  localparam int N = 8;
`ifdef RELU_REMASK_EN
  localparam bit REMASK = 1'b1;
`else
  localparam bit REMASK = 1'b0;
`endif
  localparam logic [7:0] R2 = 8'h03;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [2*N-1:0] g_input;
  logic [N-1:0]   e_input;
  logic           i_valid;
  logic           o_ready;

  logic         i_ready_a, i_ready_c, i_ready_s;
  logic [N-1:0] o_a, o_c, o_s;
  logic         o_valid_a, o_valid_c, o_valid_s;
  logic [1:0]   o_idx_a, o_idx_c;
  logic [0:0]   o_idx_s;
  logic         o_last_a, o_last_c, o_last_s;
  logic [2:0]   frame_pos_a, frame_pos_c;
  logic [0:0]   frame_pos_s;

  relu_vec_pipe #(.N(8), .M(4), .CAP(0)) dut (
    .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
    .i_valid(i_valid), .i_ready(i_ready_a), .o(o_a), .o_valid(o_valid_a),
    .o_ready(o_ready), .o_idx(o_idx_a), .o_last(o_last_a), .frame_pos(frame_pos_a));

  relu_vec_pipe #(.N(8), .M(4), .CAP(6)) dut_cap (
    .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
    .i_valid(i_valid), .i_ready(i_ready_c), .o(o_c), .o_valid(o_valid_c),
    .o_ready(o_ready), .o_idx(o_idx_c), .o_last(o_last_c), .frame_pos(frame_pos_c));

  relu_vec_pipe #(.N(8), .M(1), .CAP(0)) dut_m1 (
    .clk(clk), .rst(rst), .g_input(g_input), .e_input(e_input),
    .i_valid(i_valid), .i_ready(i_ready_s), .o(o_s), .o_valid(o_valid_s),
    .o_ready(o_ready), .o_idx(o_idx_s), .o_last(o_last_s), .frame_pos(frame_pos_s));

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ReLU from the arithmetic definition on signed integers.
  function automatic logic [7:0] relu_ref(input logic [7:0] x, input int cap);
    int sx;
    logic [7:0] r;
    sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    if (sx <= 0)                  r = 8'h00;
    else if (cap != 0 && sx > cap) r = 8'(cap);
    else                          r = 8'(sx);
    return r;
  endfunction

  function automatic logic [7:0] to_out(input logic [7:0] y, input logic [7:0] r2);
    return REMASK ? 8'(y - r2) : y;
  endfunction

  function automatic bit is_pos(input logic [7:0] x);
    return (x != 8'd0) && (x < 8'd128);
  endfunction

  // Scoreboard: every accepted element since the last reset, in order.
  typedef struct {
    logic [7:0] x;
    logic [7:0] r2;
    int         k;
    logic [2:0] fp4;
  } exp_t;

  exp_t q[$];
  bit   sb_en = 1'b0;
  int   k_cnt = 0;
  int   frame_cnt = 0;
  bit   acc_next = 1'b0;
  bit   p_rst = 1'b0;
  bit   p_stall = 1'b0;
  logic [7:0] p_o, p_oc;
  logic [1:0] p_idx;
  logic       p_last;

  // Monitor sampled mid-cycle, between the driver update and the next edge.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] x;
    if (p_rst) begin
      chk("rst_o",          o_a, 0);
      chk("rst_o_valid",    o_valid_a, 0);
      chk("rst_o_idx",      o_idx_a, 0);
      chk("rst_o_last",     o_last_a, 0);
      chk("rst_frame_pos",  frame_pos_a, 0);
      chk("rst_m1_fpos",    frame_pos_s, 0);
      chk("rst_i_ready",    i_ready_a, 1);
    end
    if (p_stall) begin
      chk("stall_o",       o_a, p_o);
      chk("stall_cap_o",   o_c, p_oc);
      chk("stall_o_idx",   o_idx_a, p_idx);
      chk("stall_o_last",  o_last_a, p_last);
      chk("stall_o_valid", o_valid_a, 1);
    end
    chk("i_ready", i_ready_a, (!o_valid_a || o_ready));
    acc_next = 1'b0;
    if (sb_en) begin
      if (rst) begin
        q.delete();
        k_cnt     = 0;
        frame_cnt = 0;
      end else begin
        if (o_valid_a && o_ready) begin
          chk("sb_have_expected", (q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_o",          o_a, to_out(relu_ref(e.x, 0), e.r2));
            chk("sb_o_idx",      o_idx_a, e.k % 4);
            chk("sb_o_last",     o_last_a, (e.k % 4) == 3);
            if ((e.k % 4) == 3)
              chk("sb_frame_pos", frame_pos_a, e.fp4);
            chk("sb_cap_valid",  o_valid_c, 1);
            chk("sb_cap_o",      o_c, to_out(relu_ref(e.x, 6), e.r2));
            chk("sb_m1_valid",   o_valid_s, 1);
            chk("sb_m1_o",       o_s, to_out(relu_ref(e.x, 0), e.r2));
            chk("sb_m1_idx",     o_idx_s, 0);
            chk("sb_m1_last",    o_last_s, 1);
            chk("sb_m1_fpos",    frame_pos_s, is_pos(e.x));
          end
        end
        if (i_valid && i_ready_a) begin
          x = 8'(g_input[15:8] + e_input);
          frame_cnt += int'(is_pos(x));
          e.x   = x;
          e.r2  = g_input[7:0];
          e.k   = k_cnt;
          e.fp4 = 3'(frame_cnt);
          q.push_back(e);
          if ((k_cnt % 4) == 3) frame_cnt = 0;
          k_cnt++;
          acc_next = 1'b1;
        end
      end
    end
    p_rst   = rst;
    p_stall = o_valid_a && !o_ready && !rst;
    p_o     = o_a;
    p_oc    = o_c;
    p_idx   = o_idx_a;
    p_last  = o_last_a;
  end

  typedef struct {
    logic [7:0] r1;
    logic [7:0] e;
    logic [7:0] y0;
    logic [7:0] y6;
    logic       pos;
    logic [2:0] fp4;
  } vec_t;

  vec_t tbl[9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] r1, input logic [7:0] e, input logic [7:0] r2);
    g_input = {r1, r2};
    e_input = e;
    i_valid = 1'b1;
  endtask

  task automatic drain;
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; g_input = '0; e_input = '0;

    tbl[0] = '{8'h10, 8'h05, 8'h15, 8'h06, 1'b1, 3'd0};
    tbl[1] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0, 3'd0};
    tbl[2] = '{8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0};
    tbl[3] = '{8'h7F, 8'h01, 8'h00, 8'h00, 1'b0, 3'd1};
    tbl[4] = '{8'h30, 8'h10, 8'h40, 8'h06, 1'b1, 3'd0};
    tbl[5] = '{8'h02, 8'h03, 8'h05, 8'h05, 1'b1, 3'd0};
    tbl[6] = '{8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd2};
    tbl[8] = '{8'h80, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0};

    tick(); tick();
    rst = 1'b0;
    chk("reset_o_valid", o_valid_a, 0);
    chk("reset_frame_pos", frame_pos_a, 0);
    chk("reset_i_ready", i_ready_a, 1);

    // Table: each beat accepted alone, result must be valid exactly two edges later.
    for (int i = 0; i < 9; i++) begin
      beat(tbl[i].r1, tbl[i].e, R2);
      tick();
      i_valid = 1'b0;
      tick();
      chk("tbl_o_valid",  o_valid_a, 1);
      chk("tbl_o",        o_a, to_out(tbl[i].y0, R2));
      chk("tbl_o_idx",    o_idx_a, i % 4);
      chk("tbl_o_last",   o_last_a, (i % 4) == 3);
      if ((i % 4) == 3)
        chk("tbl_frame_pos", frame_pos_a, tbl[i].fp4);
      chk("tbl_cap_o",    o_c, to_out(tbl[i].y6, R2));
      chk("tbl_m1_o",     o_s, to_out(tbl[i].y0, R2));
      chk("tbl_m1_idx",   o_idx_s, 0);
      chk("tbl_m1_last",  o_last_s, 1);
      chk("tbl_m1_fpos",  frame_pos_s, tbl[i].pos);
    end

    // Scoreboard phases start from a clean reset.
    sb_en = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;

    // Backpressure: four back-to-back beats, then a 3-cycle stall with a
    // fifth beat waiting, then release.
    for (int i = 0; i < 4; i++) begin
      beat(8'(8'h11 * (i + 1)), 8'(8'h20 + i), 8'(i));
      tick();
    end
    beat(8'h01, 8'h02, 8'h07);
    o_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("bp_i_ready_low", i_ready_a, 0);
    o_ready = 1'b1;
    for (int c = 0; c < 10 && !acc_next; c++) tick();
    tick();
    drain();

    // Reset after two of four beats: partial frame dropped, new frame from index 0.
    beat(8'h05, 8'h05, 8'h01); tick();
    beat(8'h06, 8'h06, 8'h01); tick();
    i_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_o_valid", o_valid_a, 0);
    for (int i = 0; i < 4; i++) begin
      beat(8'(8'h30 + 8'h40 * i), 8'h01, 8'h02);
      tick();
    end
    drain();

    // Randomized traffic with random backpressure and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if (!i_valid || acc_next) begin
        i_valid = ($urandom_range(0, 3) != 0);
        g_input = 16'($urandom);
        e_input = 8'($urandom);
      end
      o_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    drain();
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_o_valid", o_valid_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
